// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler that shares one registered ALU between two command
// requesters and returns the selected unit's result on the winner's response channel.
module alu_req_scheduler #(
    parameter int Width = 16
) (
    input  logic                 CLK,
    input  logic                 RST,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [Width-1:0]     req0_a,
    input  logic [Width-1:0]     req0_b,
    input  logic [3:0]           req0_fun,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [Width-1:0]     req1_a,
    input  logic [Width-1:0]     req1_b,
    input  logic [3:0]           req1_fun,

    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*Width-1:0]   rsp0_data,
    output logic                 rsp0_flag,

    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*Width-1:0]   rsp1_data,
    output logic                 rsp1_flag,

    output logic [Width-1:0]     alu_a,
    output logic [Width-1:0]     alu_b,
    output logic [3:0]           alu_fun,
    input  logic [2*Width-1:0]   alu_arith_out,
    input  logic [Width-1:0]     alu_logic_out,
    input  logic [Width-1:0]     alu_cmp_out,
    input  logic [Width-1:0]     alu_shift_out,
    input  logic                 alu_arith_flag,
    input  logic                 alu_logic_flag,
    input  logic                 alu_cmp_flag,
    input  logic                 alu_shift_flag,

    output logic                 busy
);

    // state | meaning
    // IDLE  | arbitrate, accept one command
    // ISSUE | ALU inputs stable, ALU registers result at end of cycle
    // WAIT  | ALU outputs valid, capture selected unit into response register
    // RESP  | response valid to granted requester until consumed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 last_grant;
    logic                 grant;
    logic                 win;
    logic                 accept;
    logic                 rsp_take;
    logic [2*Width-1:0]   rsp_data_q;
    logic                 rsp_flag_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        win        = 1'b0;
        accept     = 1'b0;
        rsp_take   = grant ? rsp1_ready : rsp0_ready;
        case (state)
            IDLE: begin
                // on a tie the requester not served last wins
                if (req0_valid && req1_valid) begin
                    win = ~last_grant;
                end else begin
                    win = req1_valid;
                end
                if (!RST) begin
                    req0_ready = req0_valid && !win;
                    req1_ready = req1_valid && win;
                end
                accept = req0_ready || req1_ready;
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = RESP;
            RESP: begin
                if (rsp_take) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fun    <= '0;
        end else if (accept) begin
            last_grant <= win;
            grant      <= win;
            alu_a      <= win ? req1_a   : req0_a;
            alu_b      <= win ? req1_b   : req0_b;
            alu_fun    <= win ? req1_fun : req0_fun;
        end
    end

    // alu_fun still holds the accepted command's function during WAIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_data_q <= '0;
            rsp_flag_q <= 1'b0;
        end else if (state == WAIT) begin
            case (alu_fun[3:2])
                2'b00: begin
                    rsp_data_q <= alu_arith_out;
                    rsp_flag_q <= alu_arith_flag;
                end
                2'b01: begin
                    rsp_data_q <= {{Width{1'b0}}, alu_logic_out};
                    rsp_flag_q <= alu_logic_flag;
                end
                2'b10: begin
                    rsp_data_q <= {{Width{1'b0}}, alu_cmp_out};
                    rsp_flag_q <= alu_cmp_flag;
                end
                default: begin
                    rsp_data_q <= {{Width{1'b0}}, alu_shift_out};
                    rsp_flag_q <= alu_shift_flag;
                end
            endcase
        end
    end

    assign rsp0_valid = (state == RESP) && !grant;
    assign rsp1_valid = (state == RESP) && grant;
    assign rsp0_data  = rsp_data_q;
    assign rsp1_data  = rsp_data_q;
    assign rsp0_flag  = rsp_flag_q;
    assign rsp1_flag  = rsp_flag_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: behavioural ALU stub plus a transaction-level
// scheduler model (queues, round-robin rule, fixed 3-cycle latency).
module tb_alu_req_scheduler;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   fun;
    } cmd_t;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]     req0_fun = '0, req1_fun = '0;
    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [2*W-1:0] rsp0_data, rsp1_data;
    logic           rsp0_flag, rsp1_flag;
    logic [W-1:0]   alu_a, alu_b;
    logic [3:0]     alu_fun;
    logic [2*W-1:0] alu_arith_out;
    logic [W-1:0]   alu_logic_out, alu_cmp_out, alu_shift_out;
    logic           alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
    logic           busy;

    alu_req_scheduler #(.Width(W)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_flag(rsp0_flag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_flag(rsp1_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_arith_out(alu_arith_out), .alu_logic_out(alu_logic_out),
        .alu_cmp_out(alu_cmp_out), .alu_shift_out(alu_shift_out),
        .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // ALU unit behaviour (environment, not the block under test)
    function automatic logic [2*W-1:0] f_arith(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [2*W-1:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    return sa + sb;
            2'd1:    return sa - sb;
            2'd2:    return sa * sb;
            default: return -sa;
        endcase
    endfunction

    function automatic logic [W-1:0] f_logic(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [W-1:0] f_cmp(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic signed [W-1:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0:    return {{(W-1){1'b0}}, (a == b)};
            2'd1:    return {{(W-1){1'b0}}, (sa < sb)};
            2'd2:    return {{(W-1){1'b0}}, (sa > sb)};
            default: return (sa < sb) ? a : b;
        endcase
    endfunction

    function automatic logic [W-1:0] f_shift(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [4:0] s;
        logic signed [W-1:0] sa;
        s  = {1'b0, b[3:0]};
        sa = $signed(a);
        case (op)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return sa >>> s;
            default: return (a << s) | (a >> (5'd16 - s));
        endcase
    endfunction

    always @(posedge CLK) begin
        alu_arith_out  <= f_arith(alu_fun[1:0], alu_a, alu_b);
        alu_logic_out  <= f_logic(alu_fun[1:0], alu_a, alu_b);
        alu_cmp_out    <= f_cmp(alu_fun[1:0], alu_a, alu_b);
        alu_shift_out  <= f_shift(alu_fun[1:0], alu_a, alu_b);
        alu_arith_flag <= f_arith(alu_fun[1:0], alu_a, alu_b) >= 32'h8000_0000;
        alu_logic_flag <= (f_logic(alu_fun[1:0], alu_a, alu_b) == '0);
        alu_cmp_flag   <= (alu_a == alu_b);
        alu_shift_flag <= f_shift(alu_fun[1:0], alu_a, alu_b) >= 16'h8000;
    end

    // Expected response for a command: {flag, zero-extended data of the selected unit}
    function automatic logic [2*W:0] expect_rsp(cmd_t c);
        logic [W-1:0] r;
        case (c.fun[3:2])
            2'b00: begin
                logic [2*W-1:0] ar;
                ar = f_arith(c.fun[1:0], c.a, c.b);
                return {ar[2*W-1], ar};
            end
            2'b01: begin
                r = f_logic(c.fun[1:0], c.a, c.b);
                return {(r == 0), 16'h0, r};
            end
            2'b10: begin
                r = f_cmp(c.fun[1:0], c.a, c.b);
                return {(c.a == c.b), 16'h0, r};
            end
            default: begin
                r = f_shift(c.fun[1:0], c.a, c.b);
                return {r[W-1], 16'h0, r};
            end
        endcase
    endfunction

    function automatic cmd_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] fun);
        cmd_t c;
        c.a = a; c.b = b; c.fun = fun;
        return c;
    endfunction

    int checks = 0;
    int errors = 0;

    cmd_t q0[$], q1[$];
    int   served[$];
    logic [2*W-1:0] last_data0, last_data1;
    int   pushed0 = 0, pushed1 = 0, got0 = 0, got1 = 0;

    logic           m_busy = 1'b0, m_grant = 1'b0, m_last = 1'b1;
    int             m_cnt = 0;
    cmd_t           m_alu = '0;
    logic [2*W:0]   m_pend = '0;
    logic [2*W:0]   m_rsp = '0;
    int             stall = 0;
    bit             rnd_rdy = 1'b0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(cmd_t c); q0.push_back(c); pushed0++; endtask
    task automatic push1(cmd_t c); q1.push_back(c); pushed1++; endtask

    // One clock cycle: drive at edge+1, compare at edge+2, advance model after next edge.
    task automatic cycle();
        logic er0, er1, in_rsp, rel;
        cmd_t c;
        c = '0;
        req0_valid = (q0.size() > 0);
        req1_valid = (q1.size() > 0);
        if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; req0_fun = q0[0].fun; end
        if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; req1_fun = q1[0].fun; end
        if (rnd_rdy) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end else begin
            rsp0_ready = (stall == 0);
            rsp1_ready = (stall == 0);
        end
        #1;
        er0    = !m_busy && req0_valid && (!req1_valid || m_last);
        er1    = !m_busy && req1_valid && (!req0_valid || !m_last);
        in_rsp = m_busy && (m_cnt == 3);
        chk("req0_ready", req0_ready, er0);
        chk("req1_ready", req1_ready, er1);
        chk("busy", busy, m_busy);
        chk("rsp0_valid", rsp0_valid, in_rsp && !m_grant);
        chk("rsp1_valid", rsp1_valid, in_rsp && m_grant);
        chk("rsp0_data", rsp0_data, m_rsp[2*W-1:0]);
        chk("rsp1_data", rsp1_data, m_rsp[2*W-1:0]);
        chk("rsp0_flag", rsp0_flag, m_rsp[2*W]);
        chk("rsp1_flag", rsp1_flag, m_rsp[2*W]);
        chk("alu_a", alu_a, m_alu.a);
        chk("alu_b", alu_b, m_alu.b);
        chk("alu_fun", alu_fun, m_alu.fun);
        rel = in_rsp && (m_grant ? rsp1_ready : rsp0_ready);
        if (rel) begin
            served.push_back(int'(m_grant));
            if (m_grant) begin last_data1 = rsp1_data; got1++; end
            else         begin last_data0 = rsp0_data; got0++; end
        end
        if (in_rsp && stall > 0) stall--;
        if (er0)      c = q0.pop_front();
        else if (er1) c = q1.pop_front();
        @(posedge CLK);
        #1;
        if (er0 || er1) begin
            m_busy = 1'b1; m_cnt = 1; m_grant = er1; m_last = er1;
            m_alu = c; m_pend = expect_rsp(c);
        end else if (rel) begin
            m_busy = 1'b0; m_cnt = 0;
        end else if (m_busy && m_cnt < 3) begin
            m_cnt++;
            if (m_cnt == 3) m_rsp = m_pend;
        end
    endtask

    task automatic drain(int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("drain_timeout", (n < max_cycles), 1);
    endtask

    task automatic do_reset();
        #3;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        RST = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_data", rsp0_data, 0);
        chk("rst_rsp1_data", rsp1_data, 0);
        chk("rst_rsp_flag", {rsp0_flag, rsp1_flag}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_fun}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_busy = 1'b0; m_cnt = 0; m_last = 1'b1; m_grant = 1'b0;
        m_alu = '0; m_rsp = '0;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        // reset with no pending work
        do_reset();
        cycle();

        // single add on req0
        push0(mk(16'd3, 16'd5, 4'b0000));
        drain(20);
        chk("add_data", last_data0, 32'h0000_0008);
        chk("add_count", got0, 1);

        // signed multiply on req1
        push1(mk(-16'sd300, 16'd200, 4'b0010));
        drain(20);
        chk("mul_data", last_data1, 32'hFFFF_15A0);

        // round-robin with a 5-cycle stall on the first response
        served.delete();
        stall = 5;
        for (int i = 0; i < 3; i++) begin
            push0(mk(W'($urandom), W'($urandom), 4'($urandom_range(0, 15))));
            push1(mk(W'($urandom), W'($urandom), 4'($urandom_range(0, 15))));
        end
        drain(100);
        chk("rr_count", served.size(), 6);
        for (int i = 0; i < 6 && i < served.size(); i++) begin
            chk($sformatf("rr_order%0d", i), served[i], i % 2);
        end

        // zero-extended logic result
        push0(mk(16'hF0F0, 16'hFF00, 4'b0100));
        drain(20);
        chk("and_data", last_data0, 32'h0000_F000);

        // reset while in WAIT: command discarded, then re-issued against a fresh tie
        served.delete();
        push0(mk(16'd100, 16'd7, 4'b0001));
        for (int n = 0; n < 10 && !(m_busy && m_cnt == 2); n++) cycle();
        chk("reach_wait", (m_busy && m_cnt == 2), 1);
        do_reset();
        chk("rst_discard", served.size(), 0);
        pushed0--;
        push0(mk(16'd100, 16'd7, 4'b0001));
        push1(mk(16'd1, 16'd2, 4'b1001));
        drain(30);
        chk("reissue_first", (served.size() > 0) ? served[0] : -1, 0);
        chk("reissue_data", last_data0, 32'h0000_005D);

        // randomized traffic with random response backpressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) push0(mk(W'($urandom), W'($urandom), 4'($urandom_range(0, 15))));
            if ($urandom_range(0, 1) == 1) push1(mk(W'($urandom), W'($urandom), 4'($urandom_range(0, 15))));
            for (int k = 0; k < int'($urandom_range(1, 6)); k++) cycle();
        end
        drain(2000);
        rnd_rdy = 1'b0;
        chk("total0", got0, pushed0);
        chk("total1", got1, pushed1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Two-requester scheduler that shares one registered ALU instance (arith/logic/compare/shift units, one-cycle result latency) between two independent command sources. It arbitrates round-robin, issues one command at a time to the ALU, captures the result of the unit the command selected, and returns that result on the winning requester's response channel. It sits between the client blocks and the ALU top level. It is the only driver of the ALU's A, B and ALU_FUN inputs.

## Interface
Parameters:
- Width, 16, ALU operand width; response data is 2*Width.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  (N = 0, 1) command valid.
- reqN_ready  out  1  command accepted this cycle.
- reqN_a  in  Width  operand A, signed.
- reqN_b  in  Width  operand B, signed.
- reqN_fun  in  4  ALU function; [3:2] selects the unit, [1:0] selects the op.
- rspN_valid  out  1  response valid.
- rspN_ready  in  1  response consumed.
- rspN_data  out  2*Width  result.
- rspN_flag  out  1  flag of the selected unit.
- alu_a  out  Width  drives ALU A.
- alu_b  out  Width  drives ALU B.
- alu_fun  out  4  drives ALU_FUN.
- alu_arith_out  in  2*Width  ALU arithmetic result.
- alu_logic_out  in  Width  ALU logic result.
- alu_cmp_out  in  Width  ALU compare result.
- alu_shift_out  in  Width  ALU shift result.
- alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag  in  1 each  ALU unit flags.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- **IDLE**
  - Arbitrate among asserted reqN_valid.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not granted last. The last_grant register resets to 1, so req0 wins the first tie.
  - reqN_ready is combinational and asserted only for the winner, only in IDLE.
  - On the handshake: latch a, b, fun and the grant index; update last_grant; go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - alu_a, alu_b and alu_fun are registered outputs loaded at the accepting edge, so they are stable throughout ISSUE.
  - The ALU registers its result at the end of ISSUE. Go to WAIT.
- **WAIT**
  - ALU outputs are valid in this cycle.
  - Capture into the response register, selected by latched fun[3:2]:
    - 00: alu_arith_out and alu_arith_flag.
    - 01: alu_logic_out and alu_logic_flag.
    - 10: alu_cmp_out and alu_cmp_flag.
    - 11: alu_shift_out and alu_shift_flag.
  - Width-wide results are zero-extended to 2*Width. Arith results are taken as-is, including the sign bits of the product.
  - Go to RESP.
- **RESP**
  - rspG_valid is high for the granted index G only.
  - rspN_data and rspN_flag are driven for both N from the shared response register. They are meaningful only while rspN_valid is high.
  - Hold until rspG_ready is sampled high, then go to IDLE.
  - The other requester's valid is ignored until IDLE.
- alu_a, alu_b and alu_fun hold their last issued values outside ISSUE and change only on acceptance.
- Requesters must hold valid and payload stable until ready. The scheduler never drops an accepted command except on reset.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to IDLE; last_grant = 1.
  - alu_a = 0, alu_b = 0, alu_fun = 0.
  - The response register is 0: rspN_data = 0 and rspN_flag = 0.
  - reqN_ready = 0, rspN_valid = 0 and busy = 0 while RST is high.
- Accept edge E0: ISSUE during cycle E0..E1, WAIT during E1..E2, rspG_valid high from E2.
- Latency is 3 cycles from acceptance to response valid.
- Minimum spacing is 4 cycles per command, when rsp_ready is held high. The next reqN_ready can assert in the cycle after the response handshake.
- Reset mid-operation (ISSUE, WAIT or RESP): the in-flight command is discarded, no response is produced, and the requester must re-issue.
- Both valid in IDLE after req1 was last served: req0 is granted, and req1 is granted on the following IDLE visit.
- rspG_ready already high on entry to RESP: the response lasts exactly one cycle.

## Test plan
- Reset/idle: assert RST mid-cycle with no requests -> all outputs 0 immediately; busy = 0; reqN_ready = 0.
- Single add: req0 a = 3, b = 5, fun = 0000, rsp0_ready = 1 -> rsp0_valid for one cycle, 3 cycles after acceptance, with rsp0_data = 0x00000008; rsp1_valid stays 0.
- Signed multiply, Width = 16: req1 a = -300, b = 200, fun = 0010 -> rsp1_data = 0xFFFF15A0.
- Zero-extension: req0 a = 0xF0F0, b = 0xFF00, fun = 0100 (AND) -> rsp0_data = 0x0000F000.
- Round-robin and backpressure: both valid continuously with 3 commands each, rsp ready low for 5 cycles on the first response -> grants in order req0, req1, req0, req1, req0, req1; first response held stable for all 5 stall cycles; no command lost or duplicated.
- Reset in WAIT: accept req0, then pulse RST during WAIT -> no rsp0_valid; FSM in IDLE; re-issued command completes normally with last_grant = 1 again.
